// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP histogram block: image geometry, FSM state codes
// and the border-pixel helper.
package lbp_pkg;

    localparam int unsigned IMG_DIM = 128;
    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned COORD_W = ADDR_W / 2;

    typedef logic [1:0] state_t;

    localparam state_t ACCUM = 2'd0;
    localparam state_t DUMP  = 2'd1;
    localparam state_t DONE  = 2'd2;

    // addr is {row, col}; a pixel is on the border if either coordinate is 0 or dim-1.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr,
                                       input int unsigned dim = IMG_DIM);
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        row = addr[ADDR_W-1:COORD_W];
        col = addr[COORD_W-1:0];
        return (row == '0) || (col == '0) ||
               (32'(row) == dim - 1) || (32'(col) == dim - 1);
    endfunction

endpackage

// File: rtl/lbp_hist_dump_ctrl.sv
// Bin-index sequencer and registered valid/ready output slice used while the
// histogram is being streamed out.
module lbp_hist_dump_ctrl #(
    parameter int unsigned CNT_W    = 15,
    parameter int unsigned NUM_BINS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             clear,
    input  logic             hist_ready,
    input  logic [CNT_W-1:0] rd_count,
    output logic [7:0]       rd_idx,
    output logic             hist_valid,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             last_hs
);

    logic             valid_q, valid_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hs;

    assign hs      = valid_q && hist_ready;
    assign last_hs = hs && (idx_q == 8'(NUM_BINS - 1));
    // Look one bin ahead while presenting, so the next count is ready on handshake.
    assign rd_idx  = valid_q ? idx_q + 8'd1 : idx_q;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        count_d = count_q;
        if (clear) begin
            valid_d = 1'b0;
            idx_d   = '0;
            count_d = '0;
        end else if (active) begin
            if (!valid_q) begin
                valid_d = 1'b1;
                count_d = rd_count;
            end else if (last_hs) begin
                valid_d = 1'b0;
            end else if (hs) begin
                idx_d   = idx_q + 8'd1;
                count_d = rd_count;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign hist_valid = valid_q;
    assign hist_bin   = idx_q;
    assign hist_count = count_q;

endmodule

// File: rtl/lbp_histogram.sv
// Accumulates a 256-bin histogram of LBP codes over one frame, then streams the bins out.
// Optional build macro LBP_HIST_SKIP_BORDER_EN excludes border pixels from the counts.
module lbp_histogram
    import lbp_pkg::*;
#(
    parameter int unsigned CNT_W    = 15,
    parameter int unsigned NUM_BINS = 256,
    parameter int unsigned IMG_DIM  = lbp_pkg::IMG_DIM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic              lbp_valid,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    input  logic              clear,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [7:0]        hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    output logic              hist_done,
    output logic              drop_err
);

`ifdef LBP_HIST_SKIP_BORDER_EN
    localparam bit SKIP_BORDER = 1'b1;
`else
    localparam bit SKIP_BORDER = 1'b0;
`endif

    state_t           state_q, state_d;
    logic             finish_q;
    logic             armed_q, armed_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] bins_q [NUM_BINS];
    logic             finish_rise;
    logic             count_pix;
    logic             last_hs;
    logic [7:0]       rd_idx;

    // armed_q blocks a dump when finish is already high on leaving reset or clear.
    assign finish_rise = finish && !finish_q && armed_q;
    assign count_pix   = lbp_valid && (state_q == ACCUM) && !clear &&
                         !(SKIP_BORDER && is_border(lbp_addr, IMG_DIM));

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (finish_rise) state_d = DUMP;
                DUMP:    if (last_hs) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
        drop_d  = clear ? 1'b0 : (drop_q || (lbp_valid && (state_q != ACCUM)));
        armed_d = clear ? !finish : (armed_q || !finish);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ACCUM;
            finish_q <= 1'b0;
            armed_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            finish_q <= finish;
            armed_q  <= armed_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
        end else if (count_pix && (bins_q[lbp_data] != '1)) begin
            bins_q[lbp_data] <= bins_q[lbp_data] + CNT_W'(1);
        end
    end

    lbp_hist_dump_ctrl #(
        .CNT_W    (CNT_W),
        .NUM_BINS (NUM_BINS)
    ) u_dump_ctrl (
        .clk        (clk),
        .reset      (reset),
        .active     (state_q == DUMP),
        .clear      (clear),
        .hist_ready (hist_ready),
        .rd_count   (bins_q[rd_idx]),
        .rd_idx     (rd_idx),
        .hist_valid (hist_valid),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .last_hs    (last_hs)
    );

    assign hist_done = (state_q == DONE);
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_lbp_histogram.sv
// Self-checking bench for lbp_histogram: a full-width and a 4-bit-counter instance
// share stimulus and are compared against a per-bin count model.
module tb_lbp_histogram;

    localparam int MAXM = 32767;
    localparam int MAXS = 15;
`ifdef LBP_HIST_SKIP_BORDER_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        int code;
        int reps;
        int ready_mode;
        int exp_m;
        int exp_s;
    } burst_t;

    logic        clk = 1'b0;
    logic        reset, clear, lbp_valid, finish, hist_ready;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        m_valid, m_done, m_drop;
    logic [7:0]  m_bin;
    logic [14:0] m_count;
    logic        s_valid, s_done, s_drop;
    logic [7:0]  s_bin;
    logic [3:0]  s_count;

    int checks   = 0;
    int failures = 0;
    int ref_cnt [256];
    int got_m [256];
    int got_s [256];
    bit inj_seen;

    always #5 clk = ~clk;

    lbp_histogram #(.CNT_W(15)) dut_m (
        .clk(clk), .reset(reset), .lbp_addr(lbp_addr), .lbp_valid(lbp_valid),
        .lbp_data(lbp_data), .finish(finish), .clear(clear), .hist_valid(m_valid),
        .hist_ready(hist_ready), .hist_bin(m_bin), .hist_count(m_count),
        .hist_done(m_done), .drop_err(m_drop)
    );

    lbp_histogram #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .lbp_addr(lbp_addr), .lbp_valid(lbp_valid),
        .lbp_data(lbp_data), .finish(finish), .clear(clear), .hist_valid(s_valid),
        .hist_ready(hist_ready), .hist_bin(s_bin), .hist_count(s_count),
        .hist_done(s_done), .drop_err(s_drop)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cap(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic bit on_border(input int row, input int col);
        return (row == 0) || (row == 127) || (col == 0) || (col == 127);
    endfunction

    task automatic clear_model();
        foreach (ref_cnt[i]) ref_cnt[i] = 0;
    endtask

    // One pixel in ACCUM; the model counts it unless the border rule excludes it.
    task automatic pixel(input int row, input int col, input int code);
        lbp_valid = 1'b1;
        lbp_addr  = {7'(row), 7'(col)};
        lbp_data  = 8'(code);
        tick();
        lbp_valid = 1'b0;
        if (!(SKIP && on_border(row, col))) ref_cnt[code]++;
    endtask

    task automatic do_clear();
        clear  = 1'b1;
        finish = 1'b0;
        tick();
        clear = 1'b0;
        clear_model();
    endtask

    // Raise finish and check the one-cycle gap before bin 0 is presented.
    task automatic start_dump();
        hist_ready = 1'b0;
        finish     = 1'b1;
        tick();
        check("dump_entry_valid_low", m_valid, 0);
        tick();
        check("dump_first_valid", m_valid, 1);
        check("dump_first_bin", m_bin, 0);
    endtask

    // mode 0: ready high, 1: pattern 1,0,0,1, 2: random. stop_at >= 0 returns when
    // that bin is presented. inject drives random lbp_valid during the dump.
    task automatic run_dump(input int mode, input int stop_at, input bit inject);
        int  hs = 0;
        int  cyc = 0;
        bit  prev_stall = 1'b0;
        int  pb = 0;
        int  pc = 0;
        foreach (got_m[i]) begin
            got_m[i] = -1;
            got_s[i] = -1;
        end
        while (cyc < 3000) begin
            case (mode)
                0:       hist_ready = 1'b1;
                1:       hist_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: hist_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject) begin
                lbp_valid = 1'($urandom_range(0, 1));
                lbp_data  = 8'($urandom);
                lbp_addr  = 14'($urandom);
                if (lbp_valid) inj_seen = 1'b1;
            end
            @(negedge clk);
            if (m_done) break;
            if (prev_stall) begin
                check("hold_bin", m_bin, pb);
                check("hold_count", m_count, pc);
            end
            if (m_valid && (stop_at >= 0) && (int'(m_bin) == stop_at)) begin
                lbp_valid = 1'b0;
                return;
            end
            if (m_valid && hist_ready) begin
                check($sformatf("bin_order_%0d", hs), m_bin, hs);
                check($sformatf("count_m_bin%0d", hs), m_count, cap(ref_cnt[hs], MAXM));
                check($sformatf("sat_valid_%0d", hs), s_valid, 1);
                check($sformatf("count_s_bin%0d", hs), s_count, cap(ref_cnt[hs], MAXS));
                if (hs < 256) begin
                    got_m[hs] = int'(m_count);
                    got_s[hs] = int'(s_count);
                end
                hs++;
            end
            prev_stall = m_valid && !hist_ready;
            pb = int'(m_bin);
            pc = int'(m_count);
            tick();
            cyc++;
        end
        lbp_valid  = 1'b0;
        hist_ready = 1'b0;
        check("dump_handshakes", hs, 256);
        check("dump_done", m_done, 1);
        check("dump_done_sat", s_done, 1);
        check("dump_valid_dropped", m_valid, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        burst_t tbl [5];
        int     row;
        int     col;
        bit     saw;

        tbl[0] = '{code: 7,   reps: 5,  ready_mode: 1, exp_m: 5,  exp_s: 5};
        tbl[1] = '{code: 255, reps: 20, ready_mode: 0, exp_m: 20, exp_s: 15};
        tbl[2] = '{code: 0,   reps: 1,  ready_mode: 2, exp_m: 1,  exp_s: 1};
        tbl[3] = '{code: 128, reps: 15, ready_mode: 1, exp_m: 15, exp_s: 15};
        tbl[4] = '{code: 42,  reps: 16, ready_mode: 2, exp_m: 16, exp_s: 15};

        reset = 1'b1; clear = 1'b0; lbp_valid = 1'b0; finish = 1'b0;
        hist_ready = 1'b0; lbp_addr = '0; lbp_data = '0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", m_valid, 0);
        check("reset_bin", m_bin, 0);
        check("reset_count", m_count, 0);
        check("reset_done", m_done, 0);
        check("reset_drop", m_drop, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Full frame: border code 0, interior 8'h55.
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++)
                pixel(r, c, on_border(r, c) ? 0 : 8'h55);
        start_dump();
        run_dump(0, -1, 1'b0);
        check("frame_bin0", got_m[0], SKIP ? 0 : 508);
        check("frame_bin85", got_m[85], 15876);
        check("frame_bin1", got_m[1], 0);
        check("frame_sat_bin85", got_s[85], 15);

        // Clear and a pixel in the same cycle: the pixel is discarded.
        clear = 1'b1; finish = 1'b0; lbp_valid = 1'b1;
        lbp_addr = {7'd5, 7'd5}; lbp_data = 8'd3;
        tick();
        clear = 1'b0; lbp_valid = 1'b0;
        clear_model();
        @(negedge clk);
        check("clear_done_low", m_done, 0);
        check("clear_valid_low", m_valid, 0);

        for (int t = 0; t < 5; t++) begin
            if (t > 0) do_clear();
            for (int i = 0; i < tbl[t].reps; i++) pixel(5, 5 + i, tbl[t].code);
            start_dump();
            run_dump(tbl[t].ready_mode, -1, 1'b0);
            check($sformatf("tbl%0d_main", t), got_m[tbl[t].code], tbl[t].exp_m);
            check($sformatf("tbl%0d_sat", t), got_s[tbl[t].code], tbl[t].exp_s);
            if (t == 0) check("clear_discard_bin3", got_m[3], 0);
        end

        // A pixel in DONE is dropped and flagged; clear resets the flag.
        lbp_valid = 1'b1; lbp_data = 8'd7; lbp_addr = {7'd9, 7'd9};
        tick();
        lbp_valid = 1'b0;
        @(negedge clk);
        check("done_drop_err", m_drop, 1);
        check("done_drop_err_sat", s_drop, 1);
        check("done_still_done", m_done, 1);
        do_clear();
        @(negedge clk);
        check("clear_drop_low", m_drop, 0);
        check("clear_done_low2", m_done, 0);
        check("clear_valid_low2", m_valid, 0);

        // Random frame with gaps, a same-code streak, and pixels injected during the dump.
        for (int i = 0; i < 400; i++) begin
            row = int'($urandom_range(0, 127));
            col = int'($urandom_range(0, 127));
            pixel(row, col, int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) tick();
        end
        for (int i = 0; i < 25; i++) pixel(64, 64, 200);
        start_dump();
        inj_seen = 1'b0;
        run_dump(2, -1, 1'b1);
        check("inject_drop_err", m_drop, inj_seen);

        // Asynchronous reset in the middle of a dump, with finish left high.
        do_clear();
        for (int i = 0; i < 3; i++) pixel(10, 10 + i, 9);
        start_dump();
        run_dump(0, 100, 1'b0);
        check("pre_reset_valid", m_valid, 1);
        reset = 1'b1;
        #1;
        check("async_reset_valid", m_valid, 0);
        check("async_reset_bin", m_bin, 0);
        check("async_reset_sat_valid", s_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_model();
        saw = 1'b0;
        for (int i = 0; i < 3; i++) pixel(20, 20 + i, 9);
        repeat (20) begin
            @(negedge clk);
            if (m_valid || m_done) saw = 1'b1;
            tick();
        end
        check("no_dump_with_held_finish", saw, 0);
        finish = 1'b0;
        tick();
        start_dump();
        run_dump(1, -1, 1'b0);
        check("post_reset_bin9", got_m[9], 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lbp_histogram.md
Name: lbp_histogram

Overview:
- Sits directly downstream of the 128x128 LBP engine and consumes its result-write stream (lbp_addr, lbp_valid, lbp_data, finish).
- Builds a 256-bin histogram of LBP codes over one frame.
- On frame finish, streams the 256 bins out over a valid/ready interface, then raises hist_done.
- Provides the per-frame texture descriptor to the classifier stage.

Parameters:
- CNT_W, 15, bin counter width; default holds 16384 pixels per frame; saturating.
- NUM_BINS, 256, number of histogram bins; fixed by the 8-bit LBP code.
- IMG_DIM, 128, image side length; used only for border detection.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- lbp_addr  input  14  {row[6:0], col[6:0]} of the current LBP result.
- lbp_valid  input  1  LBP result strobe; one pixel per high cycle.
- lbp_data  input  8  LBP code.
- finish  input  1  level from the LBP engine; high after the last pixel, stays high.
- clear  input  1  one-cycle pulse; zeroes all bins and rearms for a new frame.
- hist_valid  output  1  bin output valid.
- hist_ready  input  1  downstream accepts the bin when hist_valid && hist_ready.
- hist_bin  output  8  index of the presented bin.
- hist_count  output  CNT_W  count of the presented bin.
- hist_done  output  1  level; all 256 bins delivered.
- drop_err  output  1  sticky; lbp_valid arrived outside ACCUM.

Behaviour:
- Reset values:
  - All bins 0; state ACCUM.
  - hist_valid, hist_bin, hist_count, hist_done, drop_err all 0.
  - finish_q (finish delay register) 0.
- States:
  - ACCUM: while lbp_valid, bin[lbp_data] <= sat_inc(bin[lbp_data]). The updated value is visible internally the next cycle, and back-to-back valids to the same bin each count; the increment works directly on the register array, so there is no read-after-write hazard.
  - ACCUM -> DUMP on finish rising edge (finish && !finish_q). If lbp_valid is high in that same cycle, that pixel is counted before the transition.
  - DUMP: registered outputs present bin k. hist_valid rises the cycle after entering DUMP, with hist_bin=0.
    - On handshake, advance to k+1 the next cycle.
    - With hist_ready held high, throughput is one bin per cycle.
    - hist_bin/hist_count hold stable while hist_valid && !hist_ready.
    - Handshake on bin 255 -> DONE; hist_valid drops the next cycle.
  - DONE: hist_done=1; holds until clear.
- clear:
  - In any state: all bins 0, state ACCUM, hist_valid=0, hist_done=0, drop_err=0, bin index 0; takes effect the next cycle.
  - If clear and lbp_valid occur in the same cycle, clear wins and the pixel is discarded.
  - clear during DUMP aborts the dump mid-stream.
- lbp_valid in DUMP or DONE: ignored, does not modify bins, sets drop_err.
- Saturation: a bin at 2^CNT_W-1 stays there; it never wraps.
- finish already high when leaving reset or clear does not trigger DUMP; only a rising edge does. finish_q is updated every cycle, including during clear.
- Asynchronous reset mid-dump: immediately returns to the reset values above.

Optional Feature:
- Macro LBP_HIST_SKIP_BORDER_EN.
- When defined: pixels whose lbp_addr row or col equals 0 or IMG_DIM-1 are not counted. They are still legal and do not set drop_err. This keeps the forced-zero border codes out of bin 0.
- When undefined: every valid pixel is counted, including the border.

Decomposition:
- Shared package lbp_pkg, holding:
  - IMG_DIM and ADDR_W=14.
  - The state enum {ACCUM, DUMP, DONE}.
  - An is_border(addr) helper function.
- One natural sub-module, lbp_hist_dump_ctrl: the bin-index counter and valid/ready output register slice. The bin array and increment logic stay in the top.

Test Plan:
- Reset, then a full 16384-pixel frame: border codes 0, interior codes 8'h55, then finish rises; dump with hist_ready=1.
  - Without the macro: bin0=508, bin85=15876, all other bins 0, hist_done after 256 handshakes.
  - With the macro: bin0=0, bin85=15876.
- lbp_valid with code 8'h07 on 5 consecutive cycles, then finish -> bin7=5, verifying that back-to-back same-bin increments all count.
- Dump with hist_ready toggled 1,0,0,1 -> hist_bin/hist_count hold during the low cycles, no bin is skipped or repeated, and exactly 256 handshakes occur.
- Saturation with CNT_W=4: 20 pixels of code 8'hFF -> bin255=15.
- lbp_valid during DONE -> drop_err=1 and bins unchanged; then clear pulse -> drop_err=0, hist_done=0, and the next frame's counts start from 0.
- Reset asserted at bin 100 of a dump -> hist_valid=0 immediately. After release with finish already high, no dump starts until finish falls and rises again.
